// File: rtl/game_flow_sequencer.sv
// game_flow_sequencer: IDLE/RUN/DEAD run control for the T-Rex game.
// Turns frame_clk into frame ticks, ramps scroll speed, gates scoring.
// Ports:
//   clk, rst            system clock, async active-high reset
//   frame_clk           60 FPS clock, asynchronous to clk
//   jump, collided      debounced button level, collision level
//   gameState           00 IDLE, 01 RUN, 10 DEAD
//   obs_dx              scroll step for background/obstacles
//   frame_tick          one-clk pulse per frame_clk rising edge
//   score_en            high only while in RUN
//   run_frames          frames elapsed in current RUN (saturating)
module game_flow_sequencer #(
  parameter int DX_INIT           = 5,
  parameter int DX_MAX            = 12,
  parameter int SPEED_STEP_FRAMES = 600,
  parameter int HOLDOFF_FRAMES    = 30,
  parameter int COLLIDE_FRAMES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_clk,
  input  logic        jump,
  input  logic        collided,
  output logic [1:0]  gameState,
  output logic [3:0]  obs_dx,
  output logic        frame_tick,
  output logic        score_en,
  output logic [15:0] run_frames
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DEAD = 2'b10,
    S_BAD  = 2'b11
  } state_e;

  localparam logic [3:0] DX_I   = 4'(DX_INIT);
  localparam logic [3:0] DX_M   = 4'(DX_MAX);
  localparam logic [9:0] SPD_N  = 10'(SPEED_STEP_FRAMES);
  localparam logic [5:0] HOLD_N = 6'(HOLDOFF_FRAMES);
  localparam logic [1:0] COLL_N = 2'(COLLIDE_FRAMES);

  // frame_clk synchronizer and edge detect
  logic fs1_q, fs2_q, fprev_q, tick_q;
  logic jump_q;
  logic jump_rise;

  // state_q is kept as a plain vector so the illegal code 11
  // is representable and decoded explicitly
  logic [1:0]  state_q;
  state_e      state_d;
  logic [3:0]  dx_q, dx_d;
  logic [15:0] rf_q, rf_d;
  logic [9:0]  spd_q, spd_d;
  logic [1:0]  coll_q, coll_d;
  logic [5:0]  hold_q, hold_d;
  logic        score_q, score_d;

  assign jump_rise = jump & ~jump_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fs1_q   <= 1'b0;
      fs2_q   <= 1'b0;
      fprev_q <= 1'b0;
      tick_q  <= 1'b0;
      jump_q  <= 1'b0;
    end else begin
      fs1_q   <= frame_clk;
      fs2_q   <= fs1_q;
      fprev_q <= fs2_q;
      tick_q  <= fs2_q & ~fprev_q;
      jump_q  <= jump;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      dx_q    <= DX_I;
      rf_q    <= 16'd0;
      spd_q   <= 10'd0;
      coll_q  <= 2'd0;
      hold_q  <= 6'd0;
      score_q <= 1'b0;
    end else begin
      state_q <= state_d;
      dx_q    <= dx_d;
      rf_q    <= rf_d;
      spd_q   <= spd_d;
      coll_q  <= coll_d;
      hold_q  <= hold_d;
      score_q <= score_d;
    end
  end

  always_comb begin
    state_d = state_e'(state_q);
    dx_d    = dx_q;
    rf_d    = rf_q;
    spd_d   = spd_q;
    coll_d  = coll_q;
    hold_d  = hold_q;
    unique case (state_e'(state_q))
      S_IDLE: begin
        dx_d = DX_I;
        rf_d = 16'd0;
        // a tick coinciding with the start press is not counted
        if (jump_rise) begin
          state_d = S_RUN;
          spd_d   = 10'd0;
          coll_d  = 2'd0;
          hold_d  = 6'd0;
        end
      end
      S_RUN: begin
        if (tick_q) begin
          if (rf_q != 16'hFFFF)
            rf_d = rf_q + 16'd1;
          spd_d  = spd_q + 10'd1;
          coll_d = collided ? coll_q + 2'd1 : 2'd0;
          // death takes priority over a speed step on the same tick
          if (collided && (coll_q + 2'd1 == COLL_N)) begin
            state_d = S_DEAD;
            hold_d  = 6'd0;
          end else if (spd_q + 10'd1 == SPD_N) begin
            spd_d = 10'd0;
            if (dx_q != DX_M)
              dx_d = dx_q + 4'd1;
          end
        end
      end
      S_DEAD: begin
        if (tick_q && (hold_q != HOLD_N))
          hold_d = hold_q + 6'd1;
        // early presses are simply dropped
        if (jump_rise && (hold_q == HOLD_N)) begin
          state_d = S_IDLE;
          dx_d    = DX_I;
          rf_d    = 16'd0;
        end
      end
      S_BAD: begin
        state_d = S_IDLE;
        dx_d    = DX_I;
        rf_d    = 16'd0;
      end
    endcase
    score_d = (state_d == S_RUN);
  end

  assign gameState  = state_q;
  assign obs_dx     = dx_q;
  assign frame_tick = tick_q;
  assign score_en   = score_q;
  assign run_frames = rf_q;

endmodule

// File: tb/tb_game_flow_sequencer.sv
// tb_game_flow_sequencer: vectors, corner sequences and a
// frame-level random model for game_flow_sequencer.
module tb_game_flow_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        frame_clk = 1'b0;
  logic        jump = 1'b0;
  logic        collided = 1'b0;
  logic [1:0]  gameState;
  logic [3:0]  obs_dx;
  logic        frame_tick;
  logic        score_en;
  logic [15:0] run_frames;

  game_flow_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .frame_clk  (frame_clk),
    .jump       (jump),
    .collided   (collided),
    .gameState  (gameState),
    .obs_dx     (obs_dx),
    .frame_tick (frame_tick),
    .score_en   (score_en),
    .run_frames (run_frames)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int tick_cnt = 0;

  always @(posedge clk)
    if (frame_tick) tick_cnt <= tick_cnt + 1;

  typedef struct {
    bit          press;
    bit          coll;
    logic [1:0]  st;
    logic [15:0] rf;
  } vec_t;

  vec_t tbl[7];

  // frame-level reference model
  int m_st, m_rf, m_dx, m_spd, m_cc, m_hold;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string nm, input logic [1:0] st,
                         input logic [3:0] dx, input logic [15:0] rf);
    chk({nm, "/state"}, 32'(gameState), 32'(st));
    chk({nm, "/dx"}, 32'(obs_dx), 32'(dx));
    chk({nm, "/rf"}, 32'(run_frames), 32'(rf));
    chk({nm, "/score"}, 32'(score_en), 32'(st == 2'b01));
  endtask

  task automatic clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic frame(input logic c);
    collided = c;
    frame_clk = 1'b1;
    clks(3);
    frame_clk = 1'b0;
    clks(3);
  endtask

  task automatic frames(input int n, input logic c);
    for (int i = 0; i < n; i++) frame(c);
  endtask

  task automatic press();
    jump = 1'b1;
    clks(1);
    jump = 1'b0;
    clks(2);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clks(2);
    rst = 1'b0;
    clks(1);
  endtask

  task automatic model_frame(input bit c);
    if (m_st == 1) begin
      if (m_rf < 65535) m_rf++;
      m_spd++;
      m_cc = c ? m_cc + 1 : 0;
      if (m_cc >= 2) begin
        m_st = 2;
        m_hold = 0;
      end else if (m_spd >= 600) begin
        m_spd = 0;
        if (m_dx < 12) m_dx++;
      end
    end else if (m_st == 2) begin
      if (m_hold < 30) m_hold++;
    end
  endtask

  task automatic model_press();
    if (m_st == 0) begin
      m_st = 1;
      m_spd = 0;
      m_cc = 0;
      m_hold = 0;
    end else if (m_st == 2 && m_hold >= 30) begin
      m_st = 0;
      m_dx = 5;
      m_rf = 0;
    end
  endtask

  initial begin
    int t0;
    tbl[0] = '{1'b1, 1'b0, 2'd1, 16'd0};
    tbl[1] = '{1'b0, 1'b1, 2'd1, 16'd1};
    tbl[2] = '{1'b0, 1'b0, 2'd1, 16'd2};
    tbl[3] = '{1'b0, 1'b1, 2'd1, 16'd3};
    tbl[4] = '{1'b0, 1'b1, 2'd2, 16'd4};
    tbl[5] = '{1'b0, 1'b0, 2'd2, 16'd4};
    tbl[6] = '{1'b1, 1'b0, 2'd2, 16'd4};

    #1 rst = 1'b1;
    clks(2);
    chk_all("reset", 2'd0, 4'd5, 16'd0);
    chk("reset/tick", 32'(frame_tick), 32'd0);
    rst = 1'b0;
    clks(1);

    t0 = tick_cnt;
    frames(100, 1'b1);
    chk_all("idle100", 2'd0, 4'd5, 16'd0);
    chk("idle100/ticks", 32'(tick_cnt - t0), 32'd100);

    jump = 1'b1;
    clks(1);
    chk_all("start", 2'd1, 4'd5, 16'd0);
    jump = 1'b0;
    clks(1);

    frame_clk = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      clks(1);
      chk("tick_rise", 32'(frame_tick), 32'(i == 3));
    end
    frame_clk = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      clks(1);
      chk("tick_fall", 32'(frame_tick), 32'd0);
    end
    chk_all("run1", 2'd1, 4'd5, 16'd1);

    frames(1199, 1'b0);
    chk_all("run1200", 2'd1, 4'd7, 16'd1200);
    frames(2999, 1'b0);
    chk_all("run4199", 2'd1, 4'd11, 16'd4199);
    frame(1'b0);
    chk_all("run4200", 2'd1, 4'd12, 16'd4200);
    frames(1800, 1'b0);
    chk_all("run6000", 2'd1, 4'd12, 16'd6000);

    frame_clk = 1'b1;
    clks(1);
    #2 rst = 1'b1;
    #1;
    chk_all("async_rst", 2'd0, 4'd5, 16'd0);
    chk("async_rst/tick", 32'(frame_tick), 32'd0);
    frame_clk = 1'b0;
    clks(2);
    rst = 1'b0;
    clks(3);

    frame_clk = 1'b1;
    clks(3);
    jump = 1'b1;
    frame_clk = 1'b0;
    clks(1);
    chk_all("tick_and_jump", 2'd1, 4'd5, 16'd0);
    jump = 1'b0;
    clks(3);
    frame(1'b0);
    chk_all("tick_and_jump/next", 2'd1, 4'd5, 16'd1);

    frames(597, 1'b0);
    frame(1'b1);
    chk_all("pre_death", 2'd1, 4'd5, 16'd599);
    frame(1'b1);
    chk_all("death_vs_step", 2'd2, 4'd5, 16'd600);
    frame(1'b0);
    chk_all("dead_frozen", 2'd2, 4'd5, 16'd600);

    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].press) press();
      else frame(tbl[i].coll);
      chk_all($sformatf("vec%0d", i), tbl[i].st, 4'd5, tbl[i].rf);
    end

    frames(28, 1'b0);
    press();
    chk_all("hold29", 2'd2, 4'd5, 16'd4);
    frame(1'b0);
    press();
    chk_all("hold30", 2'd0, 4'd5, 16'd0);
    press();
    chk_all("restart", 2'd1, 4'd5, 16'd0);
    frame(1'b0);
    chk_all("restart/f1", 2'd1, 4'd5, 16'd1);

    do_reset();
    jump = 1'b1;
    clks(1);
    chk("held/start", 32'(gameState), 32'd1);
    frames(2, 1'b1);
    chk_all("held/dead", 2'd2, 4'd5, 16'd2);
    frames(40, 1'b0);
    chk("held/no_restart", 32'(gameState), 32'd2);
    jump = 1'b0;
    clks(2);
    press();
    chk("held/repress", 32'(gameState), 32'd0);

    press();
    frame(1'b0);
    chk_all("pre_illegal", 2'd1, 4'd5, 16'd1);
    force dut.state_q = 2'b11;
    #1 release dut.state_q;
    chk("illegal/set", 32'(gameState), 32'd3);
    clks(1);
    chk_all("illegal/recover", 2'd0, 4'd5, 16'd0);

    do_reset();
    m_st = 0; m_rf = 0; m_dx = 5;
    m_spd = 0; m_cc = 0; m_hold = 0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        press();
        model_press();
      end else begin
        bit c;
        c = ($urandom_range(0, 9) < 3);
        frame(c);
        model_frame(c);
      end
      chk_all($sformatf("rnd%0d", i), 2'(m_st), 4'(m_dx), 16'(m_rf));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
